// File: rtl/us_echo_if.sv
// Trigger/echo bundle between a ranging master and the echo emulator.
interface us_echo_if;
  logic       trig;
  logic [8:0] dist_cm;
  logic       echo;
  logic       busy;
  logic       trig_err;
  logic       meas_done;

  modport master (
    output trig, dist_cm,
    input  echo, busy, trig_err, meas_done
  );

  modport slave (
    input  trig, dist_cm,
    output echo, busy, trig_err, meas_done
  );
endinterface

// File: rtl/us_echo_emu.sv
// HC-SR04-style responder: accepts a trig pulse and answers
// with an echo whose width encodes the programmed distance.
module us_echo_emu #(
  parameter int unsigned CLK_FREQ_MHZ = 100,
  parameter int unsigned MIN_TRIG_US  = 10,
  parameter int unsigned BURST_US     = 200,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_US   = 38000,
  parameter int unsigned HOLDOFF_US   = 1000
) (
  input  logic  clk,
  input  logic  reset_n,
  us_echo_if.slave bus
);

  localparam logic [31:0] TRIG_MIN = 32'(MIN_TRIG_US * CLK_FREQ_MHZ);
  localparam logic [31:0] BURST_CY = 32'(BURST_US * CLK_FREQ_MHZ);
  localparam logic [31:0] HOLD_CY  = 32'(HOLDOFF_US * CLK_FREQ_MHZ);
  localparam logic [31:0] TOUT_CY  = 32'(TIMEOUT_US * CLK_FREQ_MHZ);
  localparam logic [31:0] CM_CY    = 32'(58 * CLK_FREQ_MHZ);
  localparam logic [31:0] MAX_D    = 32'(MAX_CM);

  typedef enum logic [2:0] {
    IDLE, TRIG_HI, BURST, ECHO, HOLDOFF
  } state_t;

  state_t      state;
  logic        s1, trig_s, trig_d;
  logic [31:0] cnt, width;
  logic        echo_q, busy_q, err_q, done_q;
  logic [31:0] dist32;
  logic        in_range;

  assign dist32   = 32'(bus.dist_cm);
  assign in_range = (dist32 != 0) && (dist32 <= MAX_D);

  assign bus.echo      = echo_q;
  assign bus.busy      = busy_q;
  assign bus.trig_err  = err_q;
  assign bus.meas_done = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      s1     <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
      cnt    <= '0;
      width  <= '0;
      echo_q <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      s1     <= bus.trig;
      trig_s <= s1;
      trig_d <= trig_s;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig_s && !trig_d) begin
            state  <= TRIG_HI;
            cnt    <= 32'd1;
            busy_q <= 1'b1;
          end
        end
        TRIG_HI: begin
          if (trig_s) begin
            if (cnt != '1) cnt <= cnt + 32'd1;
          end else if (cnt >= TRIG_MIN) begin
            state <= BURST;
            cnt   <= '0;
            // width is frozen here so later dist_cm changes are ignored
            width <= in_range ? dist32 * CM_CY : TOUT_CY;
          end else begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
          end
        end
        BURST: begin
          if (cnt >= BURST_CY - 32'd1) begin
            state  <= ECHO;
            cnt    <= '0;
            echo_q <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ECHO: begin
          if (cnt >= width - 32'd1) begin
            state  <= HOLDOFF;
            cnt    <= '0;
            echo_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        HOLDOFF: begin
          if (cnt >= HOLD_CY - 32'd1) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          echo_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_us_echo_emu.sv
// Directed bench for us_echo_emu with scaled-down timing
// parameters so every path completes in a short run.
module tb_us_echo_emu;

  localparam int CLK  = 2;
  localparam int MIN  = 10;
  localparam int BUR  = 20;
  localparam int MAXC = 40;
  localparam int TOUT = 3000;
  localparam int HOLD = 50;
  localparam int B    = BUR * CLK;
  localparam int H    = HOLD * CLK;
  localparam int T    = TOUT * CLK;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  us_echo_if bus ();

  us_echo_emu #(
    .CLK_FREQ_MHZ(CLK),
    .MIN_TRIG_US (MIN),
    .BURST_US    (BUR),
    .MAX_CM      (MAXC),
    .TIMEOUT_US  (TOUT),
    .HOLDOFF_US  (HOLD)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int echo_cnt = 0;
  int ovl_cnt = 0;

  always @(negedge clk) begin
    if (bus.trig_err) err_cnt++;
    if (bus.meas_done) done_cnt++;
    if (bus.echo) echo_cnt++;
    if (bus.trig_err && bus.meas_done) ovl_cnt++;
  end

  typedef struct {
    int n;
    int d;
    int d2;
    bit err;
    int w;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input int n);
    bus.trig = 1'b1;
    repeat (n) step();
    bus.trig = 1'b0;
  endtask

  task automatic expect_echo(input int w, input int d2,
                             input string nm);
    int k;
    int d0;
    d0 = done_cnt;
    k = 0;
    while (!bus.echo && k < B + 50) begin
      step();
      k++;
      if (k == 5) bus.dist_cm = 9'(d2);
    end
    chk({nm, ".delay"}, k, B + 3);
    k = 0;
    while (bus.echo && k < T + 50) begin
      step();
      k++;
    end
    chk({nm, ".width"}, k, w);
    chk({nm, ".done"}, int'(bus.meas_done), 1);
    k = 0;
    while (bus.busy && k < H + 50) begin
      step();
      k++;
    end
    chk({nm, ".hold"}, k, H);
    chk({nm, ".ndone"}, done_cnt - d0, 1);
  endtask

  initial begin
    int e0, c0, d0, k;
    vecs[0] = '{n: 24, d: 10,  d2: 10,  err: 1'b0, w: 1160};
    vecs[1] = '{n: 19, d: 10,  d2: 10,  err: 1'b1, w: 0};
    vecs[2] = '{n: 20, d: 1,   d2: 1,   err: 1'b0, w: 116};
    vecs[3] = '{n: 20, d: 0,   d2: 0,   err: 1'b0, w: T};
    vecs[4] = '{n: 30, d: 40,  d2: 40,  err: 1'b0, w: 4640};
    vecs[5] = '{n: 24, d: 41,  d2: 41,  err: 1'b0, w: T};
    vecs[6] = '{n: 24, d: 450, d2: 450, err: 1'b0, w: T};
    vecs[7] = '{n: 24, d: 10,  d2: 300, err: 1'b0, w: 1160};

    bus.trig = 1'b0;
    bus.dist_cm = '0;
    reset_n = 1'b0;
    repeat (3) step();
    chk("rst.echo", int'(bus.echo), 0);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.err", int'(bus.trig_err), 0);
    chk("rst.done", int'(bus.meas_done), 0);
    reset_n = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      bus.dist_cm = 9'(vecs[i].d);
      e0 = err_cnt;
      c0 = echo_cnt;
      pulse(vecs[i].n);
      if (vecs[i].err) begin
        repeat (10) step();
        chk({nm, ".err"}, err_cnt - e0, 1);
        chk({nm, ".busy"}, int'(bus.busy), 0);
        chk({nm, ".echo"}, echo_cnt - c0, 0);
      end else begin
        expect_echo(vecs[i].w, vecs[i].d2, nm);
        chk({nm, ".noerr"}, err_cnt - e0, 0);
      end
      repeat (3) step();
    end

    // trig retoggled in ECHO, then held high through HOLDOFF
    bus.dist_cm = 9'd5;
    d0 = done_cnt;
    c0 = echo_cnt;
    e0 = err_cnt;
    pulse(24);
    k = 0;
    while (!bus.echo && k < B + 50) begin step(); k++; end
    repeat (10) step();
    bus.trig = 1'b1;
    repeat (5) step();
    bus.trig = 1'b0;
    repeat (5) step();
    bus.trig = 1'b1;
    k = 0;
    while (bus.busy && k < 2000) begin step(); k++; end
    chk("rt.done", done_cnt - d0, 1);
    chk("rt.width", echo_cnt - c0, 580);
    repeat (50) step();
    chk("rt.idle", int'(bus.busy), 0);
    chk("rt.noerr", err_cnt - e0, 0);
    bus.trig = 1'b0;
    repeat (5) step();
    pulse(24);
    expect_echo(580, 5, "rt2");

    // reset in the middle of an echo aborts cleanly
    bus.dist_cm = 9'd10;
    d0 = done_cnt;
    pulse(24);
    k = 0;
    while (!bus.echo && k < B + 50) begin step(); k++; end
    repeat (20) step();
    chk("ar.echo_on", int'(bus.echo), 1);
    reset_n = 1'b0;
    #1;
    chk("ar.echo", int'(bus.echo), 0);
    chk("ar.busy", int'(bus.busy), 0);
    repeat (5) step();
    reset_n = 1'b1;
    repeat (5) step();
    chk("ar.nodone", done_cnt - d0, 0);
    pulse(24);
    expect_echo(1160, 10, "ar2");

    chk("overlap", ovl_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
